serial_shift_unit: RTL and testbench



---
 rtl/serial_shift_unit.sv | 198 +++++++++++++++++++
 tb/tb_serial_shift_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : serial_shift_unit
//  Purpose  : Iterative shift/rotate engine. Shifts a working register one
//             bit position per clock under control of a down-counter and a
//             three-state FSM (IDLE -> SHIFT -> DONE -> IDLE). Latency is
//             amt+1 cycles from the accepted start to the done pulse.
//
//  Ports    : clk    - system clock, rising edge
//             rst    - synchronous, active-high reset
//             start  - request pulse, only accepted while busy=0
//             op     - operation code (LSL/LSR/ROL/ROR/ASL/ASR/reserved)
//             amt    - shift amount, 0..WIDTH-1
//             din    - operand
//             busy   - operation in flight (SHIFT and DONE states)
//             done   - one-cycle pulse, dout valid
//             dout   - result register, held until the next completion
//             err    - asserted with done when the op code was reserved
//
//  Revision : 1.0 - initial release
// ============================================================================
module serial_shift_unit #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic             err
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_SHIFT = 2'd1;
   localparam logic [1:0] c_DONE  = 2'd2;

   // ------------------------------------------------------------------------
   // Operation codes
   // ------------------------------------------------------------------------
   localparam logic [2:0] c_OP_LSL = 3'b000;
   localparam logic [2:0] c_OP_LSR = 3'b001;
   localparam logic [2:0] c_OP_ROL = 3'b010;
   localparam logic [2:0] c_OP_ROR = 3'b011;
   localparam logic [2:0] c_OP_ASL = 3'b100;
   localparam logic [2:0] c_OP_ASR = 3'b101;

   localparam logic [AMT_W-1:0] c_CNT_ZERO = '0;
   localparam logic [AMT_W-1:0] c_CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_work;
   logic [AMT_W-1:0] r_cnt;
   logic [2:0]       r_op;
   logic             r_rsv;
   logic [WIDTH-1:0] r_dout;

   // ------------------------------------------------------------------------
   // Combinational wires
   // ------------------------------------------------------------------------
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] w_shifted;
   logic             w_rsv_in;
   logic             w_accept;
   logic             w_skip_shift;
   logic             w_last_shift;

   // Single-position shift of the working register for a given op code.
   function automatic logic [WIDTH-1:0] f_shift1(
      input logic [WIDTH-1:0] v,
      input logic [2:0]       o
   );
      logic [WIDTH-1:0] res;
      res = v;
      case (o)
         c_OP_LSL, c_OP_ASL: res = {v[WIDTH-2:0], 1'b0};
         c_OP_LSR:           res = {1'b0, v[WIDTH-1:1]};
         c_OP_ROL:           res = {v[WIDTH-2:0], v[WIDTH-1]};
         c_OP_ROR:           res = {v[0], v[WIDTH-1:1]};
         c_OP_ASR:           res = {v[WIDTH-1], v[WIDTH-1:1]};
         default:            res = v;
      endcase
      return res;
   endfunction

   // Reserved codes are 11x.
   assign w_rsv_in     = op[2] & op[1];
   assign w_accept     = (r_state == c_IDLE) & start;
   // Zero-length and reserved requests go straight to DONE with dout=din.
   assign w_skip_shift = (amt == c_CNT_ZERO) | w_rsv_in;
   // The counter is about to go 1->0: this is the final shift.
   assign w_last_shift = (r_state == c_SHIFT) & (r_cnt == c_CNT_ONE);
   assign w_shifted    = f_shift1(r_work, r_op);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               w_state_nxt = w_skip_shift ? c_DONE : c_SHIFT;
            end
         end
         c_SHIFT: begin
            if (r_cnt == c_CNT_ONE) begin
               w_state_nxt = c_DONE;
            end
         end
         c_DONE: begin
            w_state_nxt = c_IDLE;
         end
         default: begin
            w_state_nxt = c_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      err  = 1'b0;
      case (r_state)
         c_SHIFT: begin
            busy = 1'b1;
         end
         c_DONE: begin
            busy = 1'b1;
            done = 1'b1;
            err  = r_rsv;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign dout = r_dout;

   // ------------------------------------------------------------------------
   // Datapath: operand capture, iterative shift, counter, result register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_work <= '0;
         r_cnt  <= '0;
         r_op   <= '0;
         r_rsv  <= 1'b0;
         r_dout <= '0;
      end else begin
         if (w_accept) begin
            r_op   <= op;
            r_work <= din;
            r_rsv  <= w_rsv_in;
            // A reserved op never shifts, so its counter stays idle.
            r_cnt  <= w_rsv_in ? c_CNT_ZERO : amt;
            if (w_skip_shift) begin
               r_dout <= din;
            end
         end else if (r_state == c_SHIFT) begin
            r_work <= w_shifted;
            r_cnt  <= r_cnt - c_CNT_ONE;
            // Capture the final shift directly so dout changes only when
            // DONE is entered, never while shifting.
            if (w_last_shift) begin
               r_dout <= w_shifted;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_shift_unit
//  Purpose  : Scoreboard bench for serial_shift_unit. The driver pushes the
//             expected result, error flag and completion edge computed by a
//             whole-word arithmetic model; a monitor pops and compares on
//             every done pulse and checks held outputs in between.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_shift_unit;

   localparam int WIDTH = 8;
   localparam int AMT_W = 3;

   logic             clk;
   logic             rst;
   logic             start;
   logic [2:0]       op;
   logic [AMT_W-1:0] amt;
   logic [WIDTH-1:0] din;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] dout;
   logic             err;

   serial_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .amt   (amt),
      .din   (din),
      .busy  (busy),
      .done  (done),
      .dout  (dout),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             e;
      int               due;
   } exp_t;

   exp_t             sb[$];
   logic [WIDTH-1:0] held = '0;
   int               n_vec = 0;
   int               n_mis = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Whole-word reference model.
   function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                               input logic [WIDTH-1:0] d,
                                               input int a);
      logic [WIDTH-1:0] r;
      case (o)
         3'b000, 3'b100: r = d << a;
         3'b001:         r = d >> a;
         3'b010:         r = (a == 0) ? d : ((d << a) | (d >> (WIDTH - a)));
         3'b011:         r = (a == 0) ? d : ((d >> a) | (d << (WIDTH - a)));
         3'b101:         r = $signed(d) >>> a;
         default:        r = d;
      endcase
      return r;
   endfunction

   // Monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'd1, 32'd0);
            end else begin
               exp_t x;
               x = sb.pop_front();
               chk("dout", 32'(dout), 32'(x.d));
               chk("err", 32'(err), 32'(x.e));
               chk("done_edge", 32'(edge_cnt), 32'(x.due));
               chk("busy_with_done", 32'(busy), 32'd1);
               held = x.d;
            end
         end else begin
            chk("err_idle", 32'(err), 32'd0);
            chk("dout_hold", 32'(dout), 32'(held));
         end
      end
   end

   // Every task starts and ends 1 time unit after a rising edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [2:0] o, input int a, input logic [WIDTH-1:0] d);
      int   g;
      int   t;
      exp_t x;
      logic rsv;
      g = 0;
      while (busy && g < 100) begin
         step(1);
         g++;
      end
      if (busy) chk("busy_timeout", 32'd1, 32'd0);
      start = 1'b1;
      op    = o;
      amt   = AMT_W'(a);
      din   = d;
      step(1);
      t     = edge_cnt;
      start = 1'b0;
      // Scramble inputs; they must not affect the in-flight operation.
      op    = 3'($urandom);
      amt   = AMT_W'($urandom);
      din   = WIDTH'($urandom);
      rsv   = o[2] & o[1];
      x.d   = ref_op(o, d, a);
      x.e   = rsv;
      x.due = (rsv || a == 0) ? t : t + a;
      sb.push_back(x);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sb.delete();
      held = '0;
      step(2);
      rst = 1'b0;
   endtask

   initial begin
      int g;
      rst = 1'b0; start = 1'b0; op = '0; amt = '0; din = '0;
      #1;
      do_reset();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_err",  32'(err),  32'd0);

      // 1: LSL with busy window check (busy cycles T+1..T+3).
      issue(3'b000, 2, 8'b11001100);
      for (int i = 0; i < 3; i++) begin
         chk("busy_window", 32'(busy), 32'd1);
         step(1);
      end
      chk("busy_after", 32'(busy), 32'd0);

      // 2: LSR / ASR
      issue(3'b001, 3, 8'b11001100);
      issue(3'b101, 3, 8'b10010000);
      // 3: rotates
      issue(3'b010, 1, 8'b11101101);
      issue(3'b011, 4, 8'b00001100);
      issue(3'b010, 7, 8'b00000001);
      // 4: zero amount and reserved
      issue(3'b000, 0, 8'b10100101);
      issue(3'b110, 5, 8'b01010101);
      issue(3'b111, 0, 8'b00111100);
      step(3);

      // 5: start collisions during SHIFT and DONE are ignored.
      issue(3'b000, 3, 8'b00000001);          // now in cycle T+1
      step(1);                                 // cycle T+2
      start = 1'b1; din = 8'hFF; op = 3'b001; amt = 3'd1;
      step(1);                                 // cycle T+3
      start = 1'b0;
      step(1);                                 // cycle T+4 (DONE)
      chk("collide_done", 32'(done), 32'd1);
      start = 1'b1; din = 8'h7E; op = 3'b010; amt = 3'd2;
      step(1);
      start = 1'b0;
      step(10);
      chk("collide_sb_empty", 32'(sb.size()), 32'd0);

      // 6: reset mid-operation discards the result.
      issue(3'b000, 6, 8'b00000011);           // cycle T+1
      step(1);                                 // cycle T+2
      rst = 1'b1;
      sb.delete();
      held = '0;
      step(1);                                 // reset sampled
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_dout", 32'(dout), 32'd0);
      chk("midrst_err",  32'(err),  32'd0);
      step(10);
      issue(3'b011, 2, 8'b10000001);
      step(6);

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         issue(3'($urandom), int'($urandom_range(0, WIDTH - 1)), WIDTH'($urandom));
         if ($urandom_range(0, 3) == 0) step(int'($urandom_range(0, 4)));
      end

      g = 0;
      while (sb.size() != 0 && g < 200) begin
         step(1);
         g++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
